// File: rtl/spdif_sample_feeder_if.sv
// ---------------------------------------------------------------------------
// spdif_sample_feeder_if
//   Bundles the PCM-pair input side and the encoder-facing sub-frame side of
//   spdif_sample_feeder into one interface.
//   Optional macro: SPDIF_MUTE_EN adds the i_mute input.
//
//   Input side  : i_valid, i_ready, i_left, i_right (stereo pair handshake)
//   Output side : o_valid, o_ready, o_is_left, o_audio, o_user, o_control
//                 next_sub_frame_number (encoder sub-frame counter, 0..383)
//
//   slave  : the feeder's view (spdif_sample_feeder uses this)
//   master : the surrounding system's view (source + encoder)
// ---------------------------------------------------------------------------
interface spdif_sample_feeder_if #(
  parameter int audio_width = 24
);
  logic                   i_valid;
  logic                   i_ready;
  logic [audio_width-1:0] i_left;
  logic [audio_width-1:0] i_right;
  logic                   o_valid;
  logic                   o_ready;
  logic                   o_is_left;
  logic [audio_width-1:0] o_audio;
  logic                   o_user;
  logic                   o_control;
  logic [8:0]             next_sub_frame_number;
`ifdef SPDIF_MUTE_EN
  logic                   i_mute;

  modport slave (
    input  i_valid, i_left, i_right, o_ready, next_sub_frame_number, i_mute,
    output i_ready, o_valid, o_is_left, o_audio, o_user, o_control
  );
  modport master (
    output i_valid, i_left, i_right, o_ready, next_sub_frame_number, i_mute,
    input  i_ready, o_valid, o_is_left, o_audio, o_user, o_control
  );
`else
  modport slave (
    input  i_valid, i_left, i_right, o_ready, next_sub_frame_number,
    output i_ready, o_valid, o_is_left, o_audio, o_user, o_control
  );
  modport master (
    output i_valid, i_left, i_right, o_ready, next_sub_frame_number,
    input  i_ready, o_valid, o_is_left, o_audio, o_user, o_control
  );
`endif
endinterface

// File: rtl/spdif_sample_feeder.sv
// ---------------------------------------------------------------------------
// spdif_sample_feeder
//   Stereo-pair front end for spdif_frame_encoder. Buffers L/R PCM pairs in a
//   DEPTH-entry FIFO and presents them as alternating left/right sub-frames.
//   Generates the IEC 60958 consumer channel-status bit from the encoder's
//   sub-frame counter and realigns L/R when that counter restarts.
//   Optional macro: SPDIF_MUTE_EN (adds i_mute; zeroes o_audio for a pair
//   whose left half was accepted with i_mute=1).
//
// Ports
//   clk128  in  bit clock shared with the encoder
//   reset_n in  asynchronous reset, active low
//   bus     spdif_sample_feeder_if.slave (pair input + sub-frame output)
// ---------------------------------------------------------------------------
module spdif_sample_feeder #(
  parameter int         audio_width = 24,
  parameter int         DEPTH       = 4,
  parameter logic       CS_COPY     = 1'b1,
  parameter logic [7:0] CS_CATEGORY = 8'h00,
  parameter logic [3:0] CS_FS_CODE  = 4'b0000,
  parameter logic [3:0] CS_WORD_LEN = 4'b1011
) (
  input logic                  clk128,
  input logic                  reset_n,
  spdif_sample_feeder_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  // Channel-status block, bit n = cs[n]; indices 192..255 are never used but
  // padding to 256 lets the 8-bit frame index address it directly.
  localparam logic [255:0] CS_VEC = {220'd0, CS_WORD_LEN, 4'd0, CS_FS_CODE,
                                     8'd0, CS_CATEGORY, 5'd0, CS_COPY, 2'd0};

  typedef enum logic {
    PH_LEFT  = 1'b0,
    PH_RIGHT = 1'b1
  } phase_e;

  phase_e                 r_phase;
  logic [AW:0]            r_wr_ptr;
  logic [AW:0]            r_rd_ptr;
  logic [audio_width-1:0] r_mem_left  [DEPTH];
  logic [audio_width-1:0] r_mem_right [DEPTH];

  logic                   w_full;
  logic                   w_empty;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_expect_left;
  logic                   w_handshake;
  logic                   w_accept;
  logic                   w_mute;
  logic [audio_width-1:0] w_head;

  // Extra pointer MSB distinguishes full (wrapped) from empty (equal).
  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

  // Push depends only on full, so a same-cycle pop never frees a slot early.
  assign w_push        = bus.i_valid && !w_full;
  assign w_expect_left = !bus.next_sub_frame_number[0];
  assign w_handshake   = !w_empty && bus.o_ready;
  assign w_accept      = w_handshake && ((r_phase == PH_LEFT) == w_expect_left);
  // Any handshake in the right phase pops: either a normal right accept or an
  // encoder restart (expect_left) that drops the unsent right half.
  assign w_pop         = w_handshake && (r_phase == PH_RIGHT);

  // NOTE: the sample storage has no reset; contents are only visible through
  // o_audio while the FIFO is non-empty, so flushing the pointers suffices.
  always_ff @(posedge clk128) begin
    if (w_push) begin
      r_mem_left[r_wr_ptr[AW-1:0]]  <= bus.i_left;
      r_mem_right[r_wr_ptr[AW-1:0]] <= bus.i_right;
    end
  end

  always_ff @(posedge clk128 or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every block
      // sees the pre-edge values regardless of evaluation order.
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

`ifdef SPDIF_MUTE_EN
  logic r_mute;
`endif

  // Sub-frame phase FSM (plus the per-pair mute latch when enabled).
  always_ff @(posedge clk128 or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= PH_LEFT;
`ifdef SPDIF_MUTE_EN
      r_mute  <= 1'b0;
`endif
    end else begin
      unique case (r_phase)
        PH_LEFT: begin
          // With expect_left=0 the FSM simply holds until the encoder realigns.
          if (w_accept) begin
            r_phase <= PH_RIGHT;
`ifdef SPDIF_MUTE_EN
            r_mute  <= bus.i_mute;
`endif
          end
        end
        PH_RIGHT: begin
          if (w_handshake) r_phase <= PH_LEFT;
        end
        default: r_phase <= PH_LEFT;
      endcase
    end
  end

`ifdef SPDIF_MUTE_EN
  // The left half is latched by the encoder on the same edge that samples
  // i_mute, so it must see i_mute directly; the right half uses the latch.
  assign w_mute = (r_phase == PH_LEFT) ? bus.i_mute : r_mute;
`else
  assign w_mute = 1'b0;
`endif

  assign w_head = (r_phase == PH_LEFT) ? r_mem_left[r_rd_ptr[AW-1:0]]
                                       : r_mem_right[r_rd_ptr[AW-1:0]];

  assign bus.i_ready   = !w_full;
  assign bus.o_valid   = !w_empty;
  assign bus.o_is_left = (r_phase == PH_LEFT);
  // Forced to zero when empty so uninitialised storage never reaches the port.
  assign bus.o_audio   = (w_empty || w_mute) ? '0 : w_head;
  assign bus.o_user    = 1'b0;
  // Frame index = sub-frame number / 2, so both halves carry the same bit.
  assign bus.o_control = CS_VEC[bus.next_sub_frame_number[8:1]];

endmodule
